wptr_and_full_sync: RTL



---
 rtl/wptr_and_full_sync_if.sv | 36 +++
 rtl/wptr_and_full_sync.sv | 101 ++++++++++
 2 files changed

// File: rtl/wptr_and_full_sync_if.sv
// Write-side bundle of the async FIFO pointer block: producer request, the
// unsynchronised read pointer coming in, and the pointer/flag outputs.
// almost_full exists only when FIFO_ALMOST_FULL_EN is defined.
interface wptr_and_full_sync_if #(
   parameter int unsigned ptr_w = 11   // N+1 pointer bits (MSB = wrap bit)
);
   logic             wr_enable;
   logic [ptr_w-1:0] rptr_gray_async;
   logic [ptr_w-1:0] wptr;
   logic [ptr_w-1:0] wptr_gray;
   logic [ptr_w-1:0] rptr_bin_sync;
   logic             full;
   logic             wr_en;
   logic             overflow;
`ifdef FIFO_ALMOST_FULL_EN
   logic             almost_full;
`endif

   // producer / environment side
   modport master (
      output wr_enable, rptr_gray_async,
      input  wptr, wptr_gray, rptr_bin_sync, full, wr_en, overflow
`ifdef FIFO_ALMOST_FULL_EN
      , input almost_full
`endif
   );

   // pointer block side
   modport slave (
      input  wr_enable, rptr_gray_async,
      output wptr, wptr_gray, rptr_bin_sync, full, wr_en, overflow
`ifdef FIFO_ALMOST_FULL_EN
      , output almost_full
`endif
   );
endinterface

// File: rtl/wptr_and_full_sync.sv
// Write-domain pointer and full-flag logic of the asynchronous FIFO.
// Keeps the binary write pointer plus a registered Gray copy for the read
// domain, brings the read-domain Gray pointer in through two flops, and
// derives full, sticky overflow and the qualified memory write strobe.
// Optional feature macro: FIFO_ALMOST_FULL_EN (adds registered almost_full).
module wptr_and_full_sync #(
   parameter int unsigned width     = 32,
   parameter int unsigned depth     = 1024,
   parameter int unsigned af_margin = 4
) (
   input logic                  clk_w,
   input logic                  rst_w_gen,
   wptr_and_full_sync_if.slave  bus
);
   localparam int unsigned N  = $clog2(depth);
   localparam int unsigned PW = N + 1;

   // width only has to agree with the FIFO top; reject unusable geometries
   if (width < 1 || depth < 4 || (depth & (depth - 1)) != 0 ||
       af_margin < 1 || af_margin >= depth) begin : g_param_check
      $error("wptr_and_full_sync: illegal parameter set");
   end

   function automatic logic [PW-1:0] gray2bin(input logic [PW-1:0] g);
      logic [PW-1:0] b;
      b        = '0;
      b[PW-1]  = g[PW-1];
      for (int unsigned i = PW - 1; i > 0; i--) begin
         b[i-1] = b[i] ^ g[i-1];
      end
      return b;
   endfunction

   logic [PW-1:0] wp_q, wp_d;
   logic [PW-1:0] wptr_gray_q, wptr_gray_d;
   logic [PW-1:0] s1_q, s1_d;
   logic [PW-1:0] s2_q, s2_d;
   logic          wr_enable1_q, wr_enable1_d;
   logic          overflow_q, overflow_d;
   logic [PW-1:0] rptr_bin;
   logic          full;
   logic          wr_en;
`ifdef FIFO_ALMOST_FULL_EN
   logic          almost_full_q, almost_full_d;
   logic [PW-1:0] count_next;
`endif

   // full/strobe from registered state, and next values of every flop
   always_comb begin
      rptr_bin     = gray2bin(s2_q);
      full         = (wp_q[N] != rptr_bin[N]) && (wp_q[N-1:0] == rptr_bin[N-1:0]);
      wr_en        = wr_enable1_q & ~full;
      wp_d         = wr_en ? wp_q + 1'b1 : wp_q;
      // Gray copy is loaded from the next binary value, so it always tracks gray(wp)
      wptr_gray_d  = wp_d ^ (wp_d >> 1);
      s1_d         = bus.rptr_gray_async;
      s2_d         = s1_q;
      wr_enable1_d = bus.wr_enable;
      overflow_d   = overflow_q | (wr_enable1_q & full);
`ifdef FIFO_ALMOST_FULL_EN
      // occupancy as it will be after this edge, so the flag lines up with full
      count_next    = wp_d - gray2bin(s2_d);
      almost_full_d = (count_next >= PW'(depth - af_margin));
`endif
   end

   // state registers with synchronous active-low reset
   always_ff @(posedge clk_w) begin
      if (!rst_w_gen) begin
         wp_q          <= '0;
         wptr_gray_q   <= '0;
         s1_q          <= '0;
         s2_q          <= '0;
         wr_enable1_q  <= 1'b0;
         overflow_q    <= 1'b0;
`ifdef FIFO_ALMOST_FULL_EN
         almost_full_q <= 1'b0;
`endif
      end else begin
         wp_q          <= wp_d;
         wptr_gray_q   <= wptr_gray_d;
         s1_q          <= s1_d;
         s2_q          <= s2_d;
         wr_enable1_q  <= wr_enable1_d;
         overflow_q    <= overflow_d;
`ifdef FIFO_ALMOST_FULL_EN
         almost_full_q <= almost_full_d;
`endif
      end
   end

   assign bus.wptr          = wp_q;
   assign bus.wptr_gray     = wptr_gray_q;
   assign bus.rptr_bin_sync = rptr_bin;
   assign bus.full          = full;
   assign bus.wr_en         = wr_en;
   assign bus.overflow      = overflow_q;
`ifdef FIFO_ALMOST_FULL_EN
   assign bus.almost_full   = almost_full_q;
`endif
endmodule
